// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// One-bit full subtractor built from two half subtractors plus an OR for the borrow.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);
    assign d  = x ^ y;
    assign bo = ~x & y;
endmodule

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic d1;
    logic bo1;
    logic bo2;

    half_subtractor u_hs0 (.x(a),  .y(b),   .d(d1), .bo(bo1));
    // Second stage only borrows when a==b and a borrow is pending.
    half_subtractor u_hs1 (.x(d1), .y(bin), .d(d),  .bo(bo2));

    assign bout = bo1 | bo2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first, one bit per clock; result registered on DONE entry.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             bin_q;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             bout;
    logic             load;
    logic             last_bit;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;
`endif

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (bin_q),
        .d    (d_bit),
        .bout (bout)
    );

    // The last bit lands in diff directly, so the stored shift register never needs bit 0.
    assign res_next = {d_bit, res_sh};
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign load     = (state == IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            bin_q  <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else if (load) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            bin_q  <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
`endif
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_next[WIDTH-1:1];
            bin_q  <= bout;
            cnt    <= cnt + CW'(1);
            if (last_bit) begin
                diff   <= res_next;
                borrow <= bout;
`ifdef SERIAL_SUB_OVF_EN
                ovf    <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
`endif
            end
        end
    end

endmodule
